floppy_buffer_arbiter: RTL and testbench
========================================

FLOPPY_BUFFER_ARBITER -- requirements
Module: floppy_buffer_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port clken, input, 1, clock enable; state advances only when high.
REQ-004 SHALL have ports a_req in 1, a_we in 1, a_addr in 10, a_wdata in 8: FDC-side access request, level, held until a_ack.
REQ-005 SHALL have ports a_ack out 1, a_rdata out 8: FDC-side one-cycle completion pulse and read data.
REQ-006 SHALL have ports b_req in 1, b_we in 1, b_addr in 10, b_wdata in 8: workhorse-CPU-side request, same rules as port A.
REQ-007 SHALL have ports b_ack out 1, b_rdata out 8: workhorse-side completion pulse and read data.
REQ-008 SHALL have port b_lock, input, 1: workhorse holds the buffer exclusively during a sector fill or drain.
REQ-009 SHALL have ports ram_addr out 10, ram_we out 1, ram_wdata out 8, ram_rdata in 8: the single-port 1024x8 sector RAM with synchronous read and 1-cycle latency.
REQ-010 SHALL have port gnt, output, 2: one-hot current owner; bit0 = A, bit1 = B, 00 = idle.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, ACK; each transition requires clken=1.
REQ-012 IDLE: if any eligible request is present, SHALL select a winner, register its addr/we/wdata onto ram_*, set gnt, and go to ISSUE; otherwise stay in IDLE.
REQ-013 ISSUE: ram_we SHALL equal the winner's we qualified by clken; next state SHALL be WAIT.
REQ-014 WAIT: SHALL capture ram_rdata into the winner's rdata register (reads and writes alike); next state SHALL be ACK.
REQ-015 ACK: winner's ack SHALL be high for exactly one clk cycle; gnt SHALL clear to 00 on exit; next state SHALL be IDLE.
REQ-016 Request-to-ack latency SHALL be 4 clken cycles; a continuously held request SHALL be re-served every 4 clken cycles.
REQ-017 The loser's rdata and ack SHALL be unchanged; its rdata SHALL hold its last value until its own next access.
REQ-018 Lock: while b_lock=1, port A SHALL be ineligible; pending A requests stall without loss and are served after b_lock falls.
REQ-019 b_lock asserted mid-access to A SHALL NOT abort that access; it SHALL complete normally.
REQ-020 A request deasserted after grant SHALL still complete; the RAM write occurs and ack pulses.
REQ-021 ram_addr and ram_wdata SHALL hold their last values in IDLE; ram_we SHALL be 0 outside ISSUE.
REQ-022 Address SHALL be 10-bit; no wrap or modification is performed by the arbiter.

Reset
REQ-023 reset_n=0 SHALL force IDLE, gnt=00, a_ack=b_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, a_rdata=b_rdata=0, rr pointer=A, immediately and regardless of clken.
REQ-024 Reset during ISSUE SHALL suppress the pending write; no ack SHALL follow reset release.

Configuration
REQ-025 Macro FLOPPY_ARB_ROUNDROBIN_EN defined: on simultaneous eligible requests, winner SHALL alternate, starting with A after reset and tracked by a 1-bit pointer toggled on each contested grant.
REQ-026 Macro undefined: on simultaneous eligible requests, B SHALL always win; the pointer SHALL be absent.

Verification
REQ-027 B write addr 0x3FF data 0xA5, then A read 0x3FF -> ram_we pulse in ISSUE, a_rdata=0xA5, a_ack 4 clken cycles after a_req.
REQ-028 A and B request on the same cycle -> RR build: A, B, A order over 3 grants; non-RR build: B is served every time while held and A only when b_req falls.
REQ-029 b_lock=1 with a_req held for 20 cycles -> no a_ack, gnt never 01; b_lock=0 -> a_ack within 4 clken cycles.
REQ-030 clken toggled 1-of-3 during a B read of 0x123 -> latency of 4 enabled cycles, single b_ack pulse, ram_we stays 0.
REQ-031 reset_n pulsed low in ISSUE of an A write to 0x010 data 0x5A -> location 0x010 unchanged, no a_ack, all outputs at reset values.

Source files
------------

// File: rtl/floppy_buffer_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | floppy_buffer_arbiter_if
// | Bus bundle between the FDC port, the workhorse-CPU port and the sector RAM.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface floppy_buffer_arbiter_if;
    logic       a_req;
    logic       a_we;
    logic [9:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata;

    logic       b_req;
    logic       b_we;
    logic [9:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic       b_lock;

    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [1:0] gnt;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        input  ram_rdata,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_addr, ram_we, ram_wdata, gnt
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        output ram_rdata,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_addr, ram_we, ram_wdata, gnt
    );
endinterface
`default_nettype wire

// File: rtl/floppy_buffer_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | floppy_buffer_arbiter
// | Two-port arbiter (FDC = A, workhorse CPU = B) for a single-port 1024x8
// | sector RAM. Define FLOPPY_ARB_ROUNDROBIN_EN for round-robin on contention;
// | otherwise B has fixed priority.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module floppy_buffer_arbiter (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              clken,
    floppy_buffer_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t     state_q;
    logic [1:0] gnt_q;
    logic       we_q;
    logic [9:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;
    logic       a_ack_q;
    logic       b_ack_q;

    logic       a_elig_d;
    logic       b_elig_d;
    logic       pick_b_d;

    // The lock only fences off new A grants; an A access already granted runs on.
    assign a_elig_d = bus.a_req & ~bus.b_lock;
    assign b_elig_d = bus.b_req;

`ifdef FLOPPY_ARB_ROUNDROBIN_EN
    logic rr_q;     // 0: A wins the next contested grant, 1: B wins it
    assign pick_b_d = b_elig_d & (~a_elig_d | rr_q);
`else
    assign pick_b_d = b_elig_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            we_q      <= 1'b0;
            addr_q    <= 10'd0;
            wdata_q   <= 8'd0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
`ifdef FLOPPY_ARB_ROUNDROBIN_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            // Acks last one clk regardless of clken.
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            if (clken) begin
                case (state_q)
                    ST_IDLE: begin
                        if (a_elig_d | b_elig_d) begin
                            gnt_q   <= pick_b_d ? 2'b10 : 2'b01;
                            we_q    <= pick_b_d ? bus.b_we    : bus.a_we;
                            addr_q  <= pick_b_d ? bus.b_addr  : bus.a_addr;
                            wdata_q <= pick_b_d ? bus.b_wdata : bus.a_wdata;
`ifdef FLOPPY_ARB_ROUNDROBIN_EN
                            if (a_elig_d & b_elig_d) begin
                                rr_q <= ~rr_q;
                            end
`endif
                            state_q <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (gnt_q[1]) begin
                            b_rdata_q <= bus.ram_rdata;
                            b_ack_q   <= 1'b1;
                        end else begin
                            a_rdata_q <= bus.ram_rdata;
                            a_ack_q   <= 1'b1;
                        end
                        state_q <= ST_ACK;
                    end
                    ST_ACK: begin
                        gnt_q   <= 2'b00;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Combinational so an asynchronous reset in ISSUE kills the write before the edge.
    assign bus.ram_we    = (state_q == ST_ISSUE) & we_q & clken;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.gnt       = gnt_q;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_floppy_buffer_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_floppy_buffer_arbiter
// | Randomized bench for floppy_buffer_arbiter with a transaction-level model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_floppy_buffer_arbiter;

    typedef struct packed {
        logic       we;
        logic [9:0] addr;
        logic [7:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic reset_n;
    logic clken;

    always #5 clk = ~clk;

    floppy_buffer_arbiter_if bus ();

    floppy_buffer_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .bus     (bus)
    );

    // Sector RAM: synchronous read, one-cycle latency, write-first.
    logic [7:0] mem [0:1023];
    logic [7:0] ram_rd_q;
    int         wr_cnt;

    assign bus.ram_rdata = ram_rd_q;

    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            ram_rd_q          <= bus.ram_wdata;
            wr_cnt            <= wr_cnt + 1;
        end else begin
            ram_rd_q <= mem[bus.ram_addr];
        end
    end

    logic [7:0] ref_mem [0:1023];
    logic [7:0] last_a;
    logic [7:0] last_b;
    txn_t       qa[$];
    txn_t       qb[$];
    int         ce_mode;
    int         ce_phase;
    int         n_chk;
    int         n_pass;
`ifdef FLOPPY_ARB_ROUNDROBIN_EN
    int         rr_ptr;     // 0: A wins next contest
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outvec();
        return {25'd0, bus.gnt, bus.a_ack, bus.b_ack, bus.ram_we, bus.ram_addr,
                bus.ram_wdata, bus.a_rdata, bus.b_rdata};
    endfunction

    function automatic txn_t mk(input logic we, input logic [9:0] addr, input logic [7:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        logic [9:0] a;
        if ($urandom_range(0, 1) == 0) a = 10'h3F0 + 10'($urandom_range(0, 3));
        else                           a = 10'($urandom_range(0, 1023));
        return mk(1'($urandom_range(0, 1)), a, 8'($urandom));
    endfunction

    task automatic drive_a(input txn_t t);
        bus.a_we = t.we; bus.a_addr = t.addr; bus.a_wdata = t.data;
    endtask

    task automatic drive_b(input txn_t t);
        bus.b_we = t.we; bus.b_addr = t.addr; bus.b_wdata = t.data;
    endtask

    // Called at a negedge: sets clken for the coming edge, returns at the next negedge.
    task automatic cycle(output bit en);
        case (ce_mode)
            0:       clken = 1'b1;
            1:       clken = ($urandom_range(0, 2) != 0);
            default: begin
                clken    = (ce_phase == 0);
                ce_phase = (ce_phase + 1) % 3;
            end
        endcase
        @(posedge clk);
        en = clken;
        @(negedge clk);
    endtask

    task automatic settle(output int stray);
        bit en;
        int k;
        int n;
        stray = 0; k = 0; n = 0;
        while (k < 2 && n < 50) begin
            cycle(en);
            if (en) k++;
            n++;
            stray += int'(bus.a_ack | bus.b_ack);
        end
    endtask

    // Serves everything queued in qa/qb; each port holds req across its queue.
    task automatic run_txns();
        txn_t       sa[$];
        txn_t       sb[$];
        txn_t       t;
        int         exp_port[$];
        logic [7:0] exp_data[$];
        int         ra, rb, idx, edges, n, exp_w, w0, stray, p;
        bit         en;
        sa = qa; sb = qb;
        ra = qa.size(); rb = qb.size();
        exp_w = 0;
        while (ra > 0 || rb > 0) begin
            int win;
            if (ra > 0 && rb > 0) begin
`ifdef FLOPPY_ARB_ROUNDROBIN_EN
                win = rr_ptr;
                rr_ptr = 1 - rr_ptr;
`else
                win = 1;
`endif
            end else begin
                win = (rb > 0) ? 1 : 0;
            end
            if (win == 1) begin t = sb.pop_front(); rb--; end
            else          begin t = sa.pop_front(); ra--; end
            if (t.we) begin
                ref_mem[t.addr] = t.data;
                exp_w++;
            end
            exp_port.push_back(win);
            exp_data.push_back(ref_mem[t.addr]);
        end

        w0 = wr_cnt;
        if (qa.size() > 0) begin drive_a(qa.pop_front()); bus.a_req = 1'b1; end
        if (qb.size() > 0) begin drive_b(qb.pop_front()); bus.b_req = 1'b1; end
        edges = 0; idx = 0; n = 0;
        while (idx < exp_port.size() && n < 400) begin
            cycle(en);
            if (en) edges++;
            n++;
            if (bus.a_ack || bus.b_ack) begin
                p = bus.b_ack ? 1 : 0;
                chk("ack_port", 64'({bus.a_ack, bus.b_ack}),
                    64'((exp_port[idx] == 1) ? 2'b01 : 2'b10));
                // Service k (from 0) acks after 4k+3 enabled edges: the 4th enabled cycle of its slot.
                chk("latency", 64'(edges), 64'(4 * idx + 3));
                if (p == 1) begin
                    chk("b_rdata", 64'(bus.b_rdata), 64'(exp_data[idx]));
                    chk("a_rdata_hold", 64'(bus.a_rdata), 64'(last_a));
                    last_b = exp_data[idx];
                    if (qb.size() > 0) drive_b(qb.pop_front());
                    else               bus.b_req = 1'b0;
                end else begin
                    chk("a_rdata", 64'(bus.a_rdata), 64'(exp_data[idx]));
                    chk("b_rdata_hold", 64'(bus.b_rdata), 64'(last_b));
                    last_a = exp_data[idx];
                    if (qa.size() > 0) drive_a(qa.pop_front());
                    else               bus.a_req = 1'b0;
                end
                idx++;
            end
        end
        chk("all_served", 64'(idx), 64'(exp_port.size()));
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        settle(stray);
        chk("stray_ack", 64'(stray), 64'd0);
        chk("ram_writes", 64'(wr_cnt - w0), 64'(exp_w));
        chk("gnt_idle", 64'(bus.gnt), 64'd0);
    endtask

    task automatic run_lock_hold(input int hold);
        txn_t       t;
        logic [7:0] exp;
        int         bad, edges, n, stray;
        bit         en;
        ce_mode = 0;
        t = rnd_txn();
        if (t.we) ref_mem[t.addr] = t.data;
        exp = ref_mem[t.addr];
        bus.b_lock = 1'b1;
        drive_a(t);
        bus.a_req = 1'b1;
        bad = 0;
        repeat (hold) begin
            cycle(en);
            if (bus.a_ack || bus.gnt == 2'b01) bad++;
        end
        chk("lock_stall", 64'(bad), 64'd0);
        bus.b_lock = 1'b0;
        edges = 0; n = 0;
        while (!bus.a_ack && n < 40) begin
            cycle(en);
            if (en) edges++;
            n++;
        end
        chk("lock_release_lat", 64'(edges), 64'd3);
        chk("lock_rdata", 64'(bus.a_rdata), 64'(exp));
        last_a = exp;
        bus.a_req = 1'b0;
        settle(stray);
        chk("lock_stray", 64'(stray), 64'd0);
    endtask

    task automatic run_lock_mid();
        txn_t       t;
        logic [7:0] exp;
        int         edges, n, stray;
        bit         en;
        ce_mode = 0;
        t = rnd_txn();
        if (t.we) ref_mem[t.addr] = t.data;
        exp = ref_mem[t.addr];
        drive_a(t);
        bus.a_req = 1'b1;
        n = 0;
        while (bus.gnt != 2'b01 && n < 20) begin
            cycle(en);
            n++;
        end
        chk("mid_gnt", 64'(bus.gnt), 64'h1);
        bus.b_lock = 1'b1;
        edges = 0; n = 0;
        while (!bus.a_ack && n < 20) begin
            cycle(en);
            if (en) edges++;
            n++;
        end
        chk("mid_lat", 64'(edges), 64'd2);
        chk("mid_rdata", 64'(bus.a_rdata), 64'(exp));
        last_a = exp;
        bus.a_req = 1'b0;
        settle(stray);
        bus.b_lock = 1'b0;
        chk("mid_stray", 64'(stray), 64'd0);
    endtask

    task automatic run_reset_issue();
        int acks, n;
        bit en;
        ce_mode = 0;
        drive_a(mk(1'b1, 10'h010, 8'h5A));
        bus.a_req = 1'b1;
        n = 0;
        while (bus.gnt != 2'b01 && n < 20) begin
            cycle(en);
            n++;
        end
        chk("rst_in_issue", 64'(bus.gnt), 64'h1);
        reset_n   = 1'b0;
        bus.a_req = 1'b0;
        #1;
        chk("rst_async_outputs", outvec(), 64'd0);
        @(negedge clk);
        cycle(en);
        chk("rst_mem_kept", 64'(mem[10'h010]), 64'(ref_mem[10'h010]));
        reset_n = 1'b1;
        last_a  = 8'd0;
        last_b  = 8'd0;
`ifdef FLOPPY_ARB_ROUNDROBIN_EN
        rr_ptr  = 0;
`endif
        acks = 0;
        repeat (8) begin
            cycle(en);
            acks += int'(bus.a_ack | bus.b_ack);
        end
        chk("rst_no_ack", 64'(acks), 64'd0);
        chk("rst_outputs_after", outvec(), 64'd0);
        chk("rst_mem_after", 64'(mem[10'h010]), 64'(ref_mem[10'h010]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; ce_mode = 0; ce_phase = 0;
        last_a = 8'd0; last_b = 8'd0;
`ifdef FLOPPY_ARB_ROUNDROBIN_EN
        rr_ptr = 0;
`endif
        reset_n = 1'b0; clken = 1'b0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 10'd0; bus.a_wdata = 8'd0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 10'd0; bus.b_wdata = 8'd0;
        bus.b_lock = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     <= 8'(i * 37 + 11);
            ref_mem[i]  = 8'(i * 37 + 11);
        end
        repeat (3) @(negedge clk);
        chk("reset_state", outvec(), 64'd0);
        reset_n = 1'b1;

        // Reset in ISSUE of an A write must leave the location untouched.
        run_reset_issue();

        // Contested start right after reset: RR gives A,B,A,B; fixed priority B,B,A,A.
        qa.push_back(rnd_txn()); qa.push_back(rnd_txn());
        qb.push_back(rnd_txn()); qb.push_back(rnd_txn());
        run_txns();

        // B writes the top location, A reads it back.
        qb.push_back(mk(1'b1, 10'h3FF, 8'hA5));
        run_txns();
        qa.push_back(mk(1'b0, 10'h3FF, 8'h00));
        run_txns();

        run_lock_hold(20);
        run_lock_mid();

        // Sparse clock enable during a B read.
        ce_mode = 2; ce_phase = 1;
        qb.push_back(mk(1'b0, 10'h123, 8'h00));
        run_txns();

        for (int it = 0; it < 40; it++) begin
            int na;
            int nb;
            ce_mode = $urandom_range(0, 2);
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 3);
            if (na == 0 && nb == 0) nb = 1;
            for (int j = 0; j < na; j++) qa.push_back(rnd_txn());
            for (int j = 0; j < nb; j++) qb.push_back(rnd_txn());
            run_txns();
            if (it % 10 == 5) run_lock_hold($urandom_range(3, 12));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
